// File: rtl/dbg_byte_out_pkg.sv
//------------------------------------------------------------------------------
// dbg_byte_out_pkg
// Shared FSM encodings and debug-bus constants for the debug byte serializer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dbg_byte_out_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } dbg_state_t;

   localparam int BYTES_PER_WORD = 4;

   // Debug pin bus shape, reused by the board-level pin mapping.
   localparam int              DBG_BUS_W     = 8;
   localparam logic [7:0]      DBG_IDLE_BYTE = 8'h00;

endpackage

`default_nettype wire

// File: rtl/dbg_byte_out_sync_fifo.sv
//------------------------------------------------------------------------------
// sync_fifo
// Single-clock word FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int c_PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W:0]   r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign full  = (r_count == (c_PTR_W+1)'(DEPTH));
   assign empty = (r_count == '0);
   assign count = r_count;
   assign dout  = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/dbg_byte_out.sv
//------------------------------------------------------------------------------
// dbg_byte_out
// Captures data-memory stores into a word FIFO and streams them LSB first
// on an 8-bit debug bus with a per-byte strobe and an end-of-word marker.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dbg_byte_out
   import dbg_byte_out_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int HOLD  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic [31:0]          wr_data,
   input  logic                 clr_ovf,
   output logic [DBG_BUS_W-1:0] byte_out,
   output logic                 byte_stb,
   output logic                 last,
   output logic                 busy,
   output logic                 full,
   output logic                 overflow
);

   localparam int                  c_HOLD_W    = $clog2(HOLD);
   localparam int                  c_CNT_W     = $clog2(DEPTH) + 1;
   localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD - 1);
   localparam logic [1:0]          c_LAST_IDX  = 2'(BYTES_PER_WORD - 1);

   dbg_state_t          r_state;
   logic [31:0]         r_shift;
   logic [1:0]          r_byte_idx;
   logic [c_HOLD_W-1:0] r_hold_cnt;
   logic [7:0]          r_byte_out;
   logic                r_byte_stb;
   logic                r_last;
   logic                r_overflow;

   logic                w_pop;
   logic                w_push;
   logic                w_drop;
   logic                w_empty;
   logic                w_full;
   logic [31:0]         w_head;
   logic [c_CNT_W-1:0]  w_count;

   assign w_pop  = (r_state == ST_IDLE) && !w_empty;
   assign w_push = wr_en && (!w_full || w_pop);
   assign w_drop = wr_en && w_full && !w_pop;

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .din   (wr_data),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   // Outputs are loaded with the value the next state presents, so the
   // first byte appears in the same cycle the FSM enters SEND.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_byte_idx <= '0;
         r_hold_cnt <= '0;
         r_byte_out <= DBG_IDLE_BYTE;
         r_byte_stb <= 1'b0;
         r_last     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_state    <= ST_SEND;
                  r_shift    <= w_head;
                  r_byte_idx <= '0;
                  r_hold_cnt <= '0;
                  r_byte_out <= w_head[7:0];
                  r_byte_stb <= 1'b1;
                  r_last     <= 1'b0;
               end else begin
                  r_byte_out <= DBG_IDLE_BYTE;
                  r_byte_stb <= 1'b0;
                  r_last     <= 1'b0;
               end
            end
            ST_SEND: begin
               if (r_hold_cnt == c_HOLD_LAST) begin
                  r_hold_cnt <= '0;
                  if (r_byte_idx == c_LAST_IDX) begin
                     r_state    <= ST_GAP;
                     r_byte_out <= DBG_IDLE_BYTE;
                     r_byte_stb <= 1'b0;
                     r_last     <= 1'b0;
                  end else begin
                     r_shift    <= {8'h00, r_shift[31:8]};
                     r_byte_idx <= r_byte_idx + 2'd1;
                     r_byte_out <= r_shift[15:8];
                     r_byte_stb <= 1'b1;
                     r_last     <= ((r_byte_idx + 2'd1) == c_LAST_IDX);
                  end
               end else begin
                  r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
                  r_byte_stb <= 1'b0;
               end
            end
            ST_GAP: begin
               r_state    <= ST_IDLE;
               r_byte_out <= DBG_IDLE_BYTE;
               r_byte_stb <= 1'b0;
               r_last     <= 1'b0;
            end
            default: begin
               r_state    <= ST_IDLE;
               r_byte_out <= DBG_IDLE_BYTE;
               r_byte_stb <= 1'b0;
               r_last     <= 1'b0;
            end
         endcase
      end
   end

   // A dropped write outranks a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (clr_ovf) begin
         r_overflow <= 1'b0;
      end
   end

   assign byte_out = r_byte_out;
   assign byte_stb = r_byte_stb;
   assign last     = r_last;
   assign busy     = (r_state != ST_IDLE) || (w_count != '0);
   assign full     = w_full;
   assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_dbg_byte_out.sv
//------------------------------------------------------------------------------
// tb_dbg_byte_out
// Self-checking bench: per-cycle comparison against a word-timeline model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dbg_byte_out;

   localparam int DEPTH = 4;
   localparam int HOLD  = 4;
   localparam int PER   = 4 * HOLD + 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = '0;
   logic        clr_ovf = 1'b0;
   logic [7:0]  byte_out;
   logic        byte_stb;
   logic        last;
   logic        busy;
   logic        full;
   logic        overflow;

   wire [12:0] obs = {byte_out, byte_stb, last, busy, full, overflow};

   dbg_byte_out #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .clr_ovf  (clr_ovf),
      .byte_out (byte_out),
      .byte_stb (byte_stb),
      .last     (last),
      .busy     (busy),
      .full     (full),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model: every accepted word has a write cycle and a first-strobe cycle.
   int          m_acc[$];
   int          m_st[$];
   logic [31:0] m_wd[$];
   logic        m_ovf;
   int          m_last_st;

   function automatic void model_clear();
      m_acc.delete();
      m_st.delete();
      m_wd.delete();
      m_ovf     = 1'b0;
      m_last_st = -1000;
   endfunction

   // Words held in the FIFO during cycle c: written before c, popped at or after c.
   function automatic int occ(int c);
      int n = 0;
      for (int i = 0; i < m_st.size(); i++)
         if (m_acc[i] + 1 <= c && c <= m_st[i] - 1) n++;
      return n;
   endfunction

   function automatic bit popping(int c);
      for (int i = 0; i < m_st.size(); i++)
         if (m_st[i] - 1 == c) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [12:0] model_out(int c);
      logic [7:0] b   = 8'h00;
      logic       stb = 1'b0;
      logic       lst = 1'b0;
      logic       bsy = 1'b0;
      int         o;
      int         off;
      int         k;
      o = occ(c);
      for (int i = 0; i < m_st.size(); i++) begin
         if (c >= m_st[i] && c < m_st[i] + 4 * HOLD) begin
            off = c - m_st[i];
            k   = off / HOLD;
            b   = 8'((m_wd[i] >> (8 * k)) & 32'hFF);
            stb = (off % HOLD == 0);
            lst = (k == 3);
         end
         if (c >= m_st[i] && c <= m_st[i] + 4 * HOLD) bsy = 1'b1;
      end
      if (o > 0) bsy = 1'b1;
      return {b, stb, lst, bsy, (o == DEPTH), m_ovf};
   endfunction

   task automatic drive(input bit we, input logic [31:0] d, input bit clr);
      wr_en   = we;
      wr_data = d;
      clr_ovf = clr;
      @(negedge clk);
   endtask

   task automatic advance();
      bit drop = 1'b0;
      int s;
      if (wr_en) begin
         if (occ(cyc) < DEPTH || popping(cyc)) begin
            s = (cyc + 2 > m_last_st + PER) ? cyc + 2 : m_last_st + PER;
            m_acc.push_back(cyc);
            m_st.push_back(s);
            m_wd.push_back(wr_data);
            m_last_st = s;
         end else begin
            drop = 1'b1;
         end
      end
      if (drop) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, '0, 1'b0);
      repeat (2) @(negedge clk);
      checks++;
      if (obs !== 13'h0) begin
         errors++;
         $display("FAIL reset_state got=%h exp=%h", obs, 13'h0);
      end
      rst_n = 1'b1;
      model_clear();
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, '0, 1'b0);
         checks++;
         if (obs !== model_out(cyc)) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs, model_out(cyc));
         end
         advance();
      end
   endtask

   task automatic test_single_word();
      int t = cyc;
      for (int i = 0; i < 22; i++) begin
         drive(i == 0, 32'hDDCCBBAA, 1'b0);
         checks++;
         if (obs !== model_out(cyc)) begin
            errors++;
            $display("FAIL single_word cyc=%0d got=%h exp=%h", cyc, obs, model_out(cyc));
         end
         if (cyc == t + 2 || cyc == t + 14) begin
            checks++;
            if ({byte_stb, last, byte_out} !== ((cyc == t + 2) ? {2'b10, 8'hAA} : {2'b11, 8'hDD})) begin
               errors++;
               $display("FAIL single_strobe cyc=%0d got stb=%b last=%b byte=%h", cyc, byte_stb, last, byte_out);
            end
         end
         if (cyc == t + 19) begin
            checks++;
            if ({busy, byte_out} !== 9'h0) begin
               errors++;
               $display("FAIL single_done busy=%b byte=%h exp 0", busy, byte_out);
            end
         end
         advance();
      end
   endtask

   task automatic test_back_to_back();
      int t = cyc;
      for (int i = 0; i < 5 * PER + 6; i++) begin
         drive(i < 5, 32'(i + 1), 1'b0);
         checks++;
         if (obs !== model_out(cyc)) begin
            errors++;
            $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs, model_out(cyc));
         end
         for (int j = 0; j < 5; j++) begin
            if (cyc == t + 2 + PER * j) begin
               checks++;
               if ({byte_stb, byte_out} !== {1'b1, 8'(j + 1)}) begin
                  errors++;
                  $display("FAIL b2b_word%0d got stb=%b byte=%h exp byte=%h", j, byte_stb, byte_out, j + 1);
               end
            end
         end
         advance();
      end
   endtask

   task automatic test_overflow();
      int t = cyc;
      for (int i = 0; i < 6 * PER + 6; i++) begin
         // writes 1..6, then a lone clear, then a dropped write with a clear
         drive(i < 6 || i == 7, 32'(i + 1), i == 6 || i == 7 || i == 20);
         checks++;
         if (obs !== model_out(cyc)) begin
            errors++;
            $display("FAIL overflow cyc=%0d got=%h exp=%h", cyc, obs, model_out(cyc));
         end
         if (cyc >= t + 6 && cyc <= t + 8) begin
            checks++;
            if (overflow !== (cyc != t + 7)) begin
               errors++;
               $display("FAIL ovf_flag cyc=%0d got=%b exp=%b", cyc, overflow, cyc != t + 7);
            end
         end
         advance();
      end
   endtask

   task automatic test_push_full_pop();
      bit done = 1'b0;
      int hit  = -1;
      for (int i = 0; i < 6 * PER + 8; i++) begin
         if (i < 5) begin
            drive(1'b1, 32'hA0 + 32'(i), 1'b0);
         end else if (!done && occ(cyc) == DEPTH && popping(cyc)) begin
            drive(1'b1, 32'hF00DCAFE, 1'b0);
            done = 1'b1;
            hit  = cyc;
         end else begin
            drive(1'b0, '0, 1'b0);
         end
         checks++;
         if (obs !== model_out(cyc)) begin
            errors++;
            $display("FAIL full_pop cyc=%0d got=%h exp=%h", cyc, obs, model_out(cyc));
         end
         if (hit >= 0 && cyc == hit + 1) begin
            checks++;
            if ({full, overflow} !== 2'b10) begin
               errors++;
               $display("FAIL full_pop_accept full=%b ovf=%b exp full=1 ovf=0", full, overflow);
            end
         end
         advance();
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL full_pop_window got none exp one push-while-full-with-pop cycle");
      end
   endtask

   task automatic test_reset_mid_frame();
      int t  = cyc;
      int t2 = 0;
      for (int i = 0; i < HOLD + 3; i++) begin
         drive(i < 3, 32'h11223344 + 32'(i), 1'b0);
         checks++;
         if (obs !== model_out(cyc)) begin
            errors++;
            $display("FAIL mid_pre cyc=%0d got=%h exp=%h", cyc, obs, model_out(cyc));
         end
         advance();
      end
      // now inside byte 1 of the first word with two words queued
      drive(1'b0, '0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== 13'h0 || cyc != t + HOLD + 3) begin
         errors++;
         $display("FAIL mid_reset_zero cyc=%0d got=%h exp=%h", cyc, obs, 13'h0);
      end
      model_clear();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < 30; i++) begin
         drive(i == 10, 32'hCAFEF00D, 1'b0);
         if (i == 10) t2 = cyc;
         checks++;
         if (obs !== model_out(cyc)) begin
            errors++;
            $display("FAIL mid_after cyc=%0d got=%h exp=%h", cyc, obs, model_out(cyc));
         end
         if (i == 12) begin
            checks++;
            if (cyc != t2 + 2 || {byte_stb, byte_out} !== {1'b1, 8'h0D}) begin
               errors++;
               $display("FAIL mid_latency got stb=%b byte=%h exp stb=1 byte=0d", byte_stb, byte_out);
            end
         end
         advance();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom % 5) == 0, $urandom, ($urandom % 23) == 0);
         checks++;
         if (obs !== model_out(cyc)) begin
            errors++;
            $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, model_out(cyc));
         end
         advance();
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_single_word();
      test_back_to_back();
      test_overflow();
      test_push_full_pop();
      test_reset_mid_frame();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
